datapath: RTL and testbench

Register file and function unit slice of the single-cycle-per-state CPU. Sits directly downstream of the control path:
- It consumes the decoded fields DR, SA, SB and FS and the strobes MB, MD and RW.
- It returns Bus A (the low nibble feeds the program counter's jump path) and the zero status Z (feeds branch evaluation in the control logic).
- Bus A and Bus B also drive the data memory's address and write-data inputs, through the external MM mux.

---
 rtl/datapath_pkg.sv | 31 +++
 rtl/datapath_register_file.sv | 36 +++
 rtl/datapath.sv | 104 ++++++++++
 tb/tb_datapath.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared CPU datapath constants: bus width, register count and function-select codes.
// Imported by the datapath top, its register file and the control logic.
package datapath_pkg;

  localparam int DP_WIDTH = 16;
  localparam int DP_NREG  = 16;
  localparam int DP_AW    = 4;

  localparam logic [3:0] FS_PASSA     = 4'b0000;
  localparam logic [3:0] FS_INC       = 4'b0001;
  localparam logic [3:0] FS_ADD       = 4'b0010;
  localparam logic [3:0] FS_ADDC      = 4'b0011;
  localparam logic [3:0] FS_SUBM1     = 4'b0100;
  localparam logic [3:0] FS_SUB       = 4'b0101;
  localparam logic [3:0] FS_DEC       = 4'b0110;
  localparam logic [3:0] FS_PASSA_ALT = 4'b0111;
  localparam logic [3:0] FS_AND       = 4'b1000;
  localparam logic [3:0] FS_OR        = 4'b1001;
  localparam logic [3:0] FS_XOR       = 4'b1010;
  localparam logic [3:0] FS_NOT       = 4'b1011;
  localparam logic [3:0] FS_PASSB     = 4'b1100;
  localparam logic [3:0] FS_SHR       = 4'b1101;
  localparam logic [3:0] FS_SHL       = 4'b1110;
  localparam logic [3:0] FS_ZERO      = 4'b1111;

  // Only the adder-based codes produce meaningful carry and overflow.
  function automatic logic is_arith(input logic [3:0] fs);
    return (fs >= FS_INC) && (fs <= FS_DEC);
  endfunction

endpackage

// File: rtl/datapath_register_file.sv
// 16-entry register file: one synchronous write port, two combinational read ports.
// Write visible on reads after the edge; reset clears every entry asynchronously.
module register_file
  import datapath_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH,
  parameter int NREG  = DP_NREG
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [DP_AW-1:0] i_wa,
  input  logic [WIDTH-1:0] i_wd,
  input  logic [DP_AW-1:0] i_ra_a,
  input  logic [DP_AW-1:0] i_ra_b,
  output logic [WIDTH-1:0] o_rd_a,
  output logic [WIDTH-1:0] o_rd_b
);

  logic [WIDTH-1:0] r_regs [NREG];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // No bypass: a same-cycle write is not seen until after the edge.
  assign o_rd_a = r_regs[i_ra_a];
  assign o_rd_b = r_regs[i_ra_b];

endmodule

// File: rtl/datapath.sv
// CPU datapath slice: register file, Bus B constant mux, function unit with Z/N/C/V, write-back mux.
// Reads and flags are combinational; register write lands one edge later; no flow control.
module datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH,
  parameter int NREG  = DP_NREG
) (
  input  logic             clk_main,
  input  logic             reset,
  input  logic [3:0]       DR,
  input  logic [3:0]       SA,
  input  logic [3:0]       SB,
  input  logic [3:0]       FS,
  input  logic             MB,
  input  logic             MD,
  input  logic             RW,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] BusA,
  output logic [WIDTH-1:0] BusB,
  output logic [WIDTH-1:0] F,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V
);

  logic [WIDTH-1:0] w_rd_b;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_y;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_arith;
  logic [WIDTH-1:0] w_f;

  register_file #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_regs (
    .i_clk  (clk_main),
    .i_rst  (reset),
    .i_we   (RW),
    .i_wa   (DR),
    .i_wd   (w_wd),
    .i_ra_a (SA),
    .i_ra_b (SB),
    .o_rd_a (BusA),
    .o_rd_b (w_rd_b)
  );

  assign BusB = MB ? {{(WIDTH-4){1'b0}}, SB} : w_rd_b;

  // Every arithmetic code is A + y + cin through one shared adder.
  always_comb begin
    w_y   = '0;
    w_cin = 1'b0;
    case (FS)
      FS_INC:   w_cin = 1'b1;
      FS_ADD:   w_y   = BusB;
      FS_ADDC: begin
        w_y   = BusB;
        w_cin = 1'b1;
      end
      FS_SUBM1: w_y   = ~BusB;
      FS_SUB: begin
        w_y   = ~BusB;
        w_cin = 1'b1;
      end
      FS_DEC:   w_y   = '1;
      default: begin
        w_y   = '0;
        w_cin = 1'b0;
      end
    endcase
    w_sum = {1'b0, BusA} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
  end

  always_comb begin
    w_f = '0;
    case (FS)
      FS_PASSA, FS_PASSA_ALT: w_f = BusA;
      FS_INC, FS_ADD, FS_ADDC,
      FS_SUBM1, FS_SUB, FS_DEC: w_f = w_sum[WIDTH-1:0];
      FS_AND:   w_f = BusA & BusB;
      FS_OR:    w_f = BusA | BusB;
      FS_XOR:   w_f = BusA ^ BusB;
      FS_NOT:   w_f = ~BusA;
      FS_PASSB: w_f = BusB;
      FS_SHR:   w_f = {1'b0, BusB[WIDTH-1:1]};
      FS_SHL:   w_f = {BusB[WIDTH-2:0], 1'b0};
      FS_ZERO:  w_f = '0;
      default:  w_f = '0;
    endcase
  end

  assign w_arith = is_arith(FS);
  assign F       = w_f;
  assign Z       = (w_f == '0);
  assign N       = w_f[WIDTH-1];
  assign C       = w_arith & w_sum[WIDTH];
  assign V       = w_arith & (BusA[WIDTH-1] == w_y[WIDTH-1]) & (w_f[WIDTH-1] != BusA[WIDTH-1]);
  assign w_wd    = MD ? DataIn : w_f;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed scenarios plus randomized cycles against an arithmetic model.
module tb_datapath;

  logic        clk_main = 1'b0;
  logic        reset;
  logic [3:0]  DR, SA, SB, FS;
  logic        MB, MD, RW;
  logic [15:0] DataIn;
  logic [15:0] BusA, BusB, F;
  logic        Z, N, C, V;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_r [16];

  datapath #(.WIDTH(16), .NREG(16)) dut (
    .clk_main (clk_main),
    .reset    (reset),
    .DR       (DR),
    .SA       (SA),
    .SB       (SB),
    .FS       (FS),
    .MB       (MB),
    .MD       (MD),
    .RW       (RW),
    .DataIn   (DataIn),
    .BusA     (BusA),
    .BusB     (BusB),
    .F        (F),
    .Z        (Z),
    .N        (N),
    .C        (C),
    .V        (V)
  );

  always #5 clk_main = ~clk_main;

  // Reference function unit in plain integer arithmetic: returns {C, V, F}.
  function automatic logic [17:0] model_alu(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b);
    int u, s, ua, ub, sa, sb;
    logic [15:0] f;
    logic c, v, ar;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    u  = 0;
    s  = 0;
    ar = 1'b1;
    f  = 16'h0000;
    case (fs)
      4'd1: begin u = ua + 1;              s = sa + 1;      end
      4'd2: begin u = ua + ub;             s = sa + sb;     end
      4'd3: begin u = ua + ub + 1;         s = sa + sb + 1; end
      4'd4: begin u = ua + 65535 - ub;     s = sa - sb - 1; end
      4'd5: begin u = ua + 65536 - ub;     s = sa - sb;     end
      4'd6: begin u = ua + 65535;          s = sa - 1;      end
      default: ar = 1'b0;
    endcase
    if (ar) begin
      f = u[15:0];
      c = (u > 65535);
      v = (s > 32767) || (s < -32768);
    end else begin
      c = 1'b0;
      v = 1'b0;
      case (fs)
        4'd0, 4'd7: f = a;
        4'd8:  f = a & b;
        4'd9:  f = a | b;
        4'd10: f = a ^ b;
        4'd11: f = ~a;
        4'd12: f = b;
        4'd13: f = b / 2;
        4'd14: f = 16'((ub * 2) % 65536);
        default: f = 16'h0000;
      endcase
    end
    return {c, v, f};
  endfunction

  function automatic logic [15:0] m_busb();
    return MB ? {12'h000, SB} : m_r[SB];
  endfunction

  // Advance one clock edge, applying the architectural write to the model.
  task automatic tick();
    logic [17:0] e;
    e = model_alu(FS, m_r[SA], m_busb());
    if (reset) begin
      for (int i = 0; i < 16; i++) m_r[i] = 16'h0000;
    end else if (RW) begin
      m_r[DR] = MD ? DataIn : e[15:0];
    end
    @(posedge clk_main);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] r, input logic [15:0] val);
    RW = 1'b1; MD = 1'b1; DR = r; DataIn = val;
    tick();
    RW = 1'b0; MD = 1'b0;
  endtask

  task automatic test_reset();
    RW = 1'b1; MD = 1'b1; DR = 4'd5; DataIn = 16'hABCD; SA = 4'd5; SB = 4'd0;
    MB = 1'b0; FS = 4'b0000;
    reset = 1'b1;
    #1;
    n_checks++;
    if (BusA !== 16'h0000 || Z !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: BusA=%h Z=%b required BusA=0000 Z=1", BusA, Z);
    end
    for (int i = 0; i < 16; i++) m_r[i] = 16'h0000;
    tick();
    RW = 1'b0;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      SA = 4'(i);
      #1;
      n_checks++;
      if (BusA !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_scan R%0d: got %h required 0000", i, BusA);
      end
    end
    // Reset landing in the middle of a write must discard it.
    write_reg(4'd9, 16'h1111);
    RW = 1'b1; MD = 1'b1; DR = 4'd9; DataIn = 16'h1234;
    #2;
    reset = 1'b1;
    tick();
    RW = 1'b0;
    reset = 1'b0;
    SA = 4'd9;
    #1;
    n_checks++;
    if (BusA !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_write: R9=%h required 0000", BusA);
    end
  endtask

  task automatic test_load_add();
    write_reg(4'd1, 16'h7FFF);
    write_reg(4'd2, 16'h0001);
    SA = 4'd1; SB = 4'd2; MB = 1'b0; FS = 4'b0010;
    #1;
    n_checks++;
    if ({F, N, V, C, Z} !== {16'h8000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_overflow: F=%h N=%b V=%b C=%b Z=%b required F=8000 N=1 V=1 C=0 Z=0", F, N, V, C, Z);
    end
    RW = 1'b1; MD = 1'b0; DR = 4'd3;
    tick();
    RW = 1'b0;
    SA = 4'd3;
    #1;
    n_checks++;
    if (BusA !== 16'h8000) begin
      n_fail++;
      $display("FAIL add_writeback: R3=%h required 8000", BusA);
    end
  endtask

  task automatic test_wrap_zero();
    write_reg(4'd4, 16'hFFFF);
    SA = 4'd4; SB = 4'd4; MB = 1'b0; FS = 4'b0001;
    #1;
    n_checks++;
    if ({F, C, Z, V} !== {16'h0000, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL inc_wrap: F=%h C=%b Z=%b V=%b required F=0000 C=1 Z=1 V=0", F, C, Z, V);
    end
    FS = 4'b0101;
    #1;
    n_checks++;
    if ({F, C, Z} !== {16'h0000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_self: F=%h C=%b Z=%b required F=0000 C=1 Z=1", F, C, Z);
    end
  endtask

  task automatic test_const_shift();
    logic [15:0] exp_f [3];
    logic [3:0]  fs_seq [3];
    write_reg(4'd6, 16'h5A5A);
    exp_f[0] = 16'h0006; exp_f[1] = 16'h000C; exp_f[2] = 16'h0003;
    fs_seq[0] = 4'b1100; fs_seq[1] = 4'b1110; fs_seq[2] = 4'b1101;
    MB = 1'b1; SB = 4'd6;
    for (int i = 0; i < 3; i++) begin
      FS = fs_seq[i];
      #1;
      n_checks++;
      if (F !== exp_f[i] || C !== 1'b0 || V !== 1'b0) begin
        n_fail++;
        $display("FAIL const_fs%b: F=%h C=%b V=%b required F=%h C=0 V=0", FS, F, C, V, exp_f[i]);
      end
    end
    MB = 1'b0;
    SA = 4'd6;
    #1;
    n_checks++;
    if (BusA !== 16'h5A5A || BusB !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL const_r6_intact: BusA=%h BusB=%h required 5A5A", BusA, BusB);
    end
  endtask

  task automatic test_same_reg();
    write_reg(4'd7, 16'h0009);
    SA = 4'd7; DR = 4'd7; FS = 4'b0110; MB = 1'b0; MD = 1'b0; RW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (BusA !== 16'(9 - i) || F !== 16'(8 - i)) begin
        n_fail++;
        $display("FAIL rmw_cycle%0d: BusA=%h F=%h required BusA=%h F=%h", i, BusA, F, 16'(9 - i), 16'(8 - i));
      end
      tick();
    end
    RW = 1'b0;
    #1;
    n_checks++;
    if (BusA !== 16'h0006) begin
      n_fail++;
      $display("FAIL rmw_final: R7=%h required 0006", BusA);
    end
  endtask

  task automatic test_no_write();
    logic [15:0] snap [16];
    for (int i = 0; i < 16; i++) snap[i] = m_r[i];
    RW = 1'b0;
    for (int k = 0; k < 10; k++) begin
      DR = 4'($urandom_range(0, 15));
      FS = 4'($urandom_range(0, 15));
      MD = 1'($urandom_range(0, 1));
      DataIn = 16'($urandom);
      tick();
    end
    MB = 1'b0;
    for (int i = 0; i < 16; i++) begin
      SA = 4'(i);
      #1;
      n_checks++;
      if (BusA !== snap[i]) begin
        n_fail++;
        $display("FAIL no_write R%0d: got %h required %h", i, BusA, snap[i]);
      end
    end
    FS = 4'b1111;
    #1;
    n_checks++;
    if ({F, Z, C, V} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL fs_zero: F=%h Z=%b C=%b V=%b required F=0000 Z=1 C=0 V=0", F, Z, C, V);
    end
  endtask

  task automatic test_random();
    logic [17:0] e;
    logic [15:0] ea, eb;
    for (int k = 0; k < 300; k++) begin
      DR = 4'($urandom_range(0, 15));
      SA = 4'($urandom_range(0, 15));
      SB = 4'($urandom_range(0, 15));
      FS = 4'($urandom_range(0, 15));
      MB = 1'($urandom_range(0, 1));
      MD = ($urandom_range(0, 3) == 0);
      RW = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: DataIn = 16'h7FFF;
        1: DataIn = 16'h8000;
        2: DataIn = 16'hFFFF;
        default: DataIn = 16'($urandom);
      endcase
      #1;
      ea = m_r[SA];
      eb = m_busb();
      e  = model_alu(FS, ea, eb);
      n_checks++;
      if ({BusA, BusB, F, Z, N, C, V} !== {ea, eb, e[15:0], (e[15:0] == 16'h0000), e[15], e[17], e[16]}) begin
        n_fail++;
        $display("FAIL random%0d fs=%b: A=%h B=%h F=%h ZNCV=%b%b%b%b required A=%h B=%h F=%h ZNCV=%b%b%b%b",
                 k, FS, BusA, BusB, F, Z, N, C, V, ea, eb, e[15:0], (e[15:0] == 16'h0000), e[15], e[17], e[16]);
      end
      tick();
    end
    RW = 1'b0;
  endtask

  initial begin
    reset = 1'b0; RW = 1'b0; MD = 1'b0; MB = 1'b0;
    DR = 4'd0; SA = 4'd0; SB = 4'd0; FS = 4'd0; DataIn = 16'h0000;
    for (int i = 0; i < 16; i++) m_r[i] = 16'h0000;
    #2;
    test_reset();
    test_load_add();
    test_wrap_zero();
    test_const_shift();
    test_same_reg();
    test_no_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
